// File: rtl/reorder_buffer_pkg.sv
// Shared sizing parameters and entry layout for the banked reorder buffer.
package reorder_buffer_pkg;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int ROB_ADDR_WIDTH       = 3;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int ROB_ROWS             = 2 ** ROB_ADDR_WIDTH;

  typedef struct packed {
    logic                            valid;
    logic                            done;
    logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    logic [4:0]                      arch_rd;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_rob_bank.sv
// One bank of the reorder buffer: ROB_ROWS entries, a dispatch write port,
// DISPATCH_WIDTH writeback done-set ports and a head-row read/clear port.
module rob_bank
  import reorder_buffer_pkg::*;
#(
  parameter int BANK = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [ROB_ADDR_WIDTH-1:0]       wr_addr,
  input  logic                            wr_valid,
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] wr_phys_rd,
  input  logic [4:0]                      wr_arch_rd,
  input  logic                            wb_en   [0:DISPATCH_WIDTH-1],
  input  logic [ROB_ADDR_WIDTH-1:0]       wb_addr [0:DISPATCH_WIDTH-1],
  input  logic [DISPATCH_WIDTH-1:0]       wb_bank [0:DISPATCH_WIDTH-1],
  input  logic                            clr_en,
  input  logic [ROB_ADDR_WIDTH-1:0]       rd_addr,
  output rob_entry_t                      rd_entry
);
  logic [ROB_ROWS-1:0]             valid_q;
  logic [ROB_ROWS-1:0]             done_q;
  logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_q [0:ROB_ROWS-1];
  logic [4:0]                      arch_q [0:ROB_ROWS-1];

  // Later assignments win: a retiring row is cleared even if written back again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      for (int p = 0; p < DISPATCH_WIDTH; p++) begin
        if (wb_en[p] && wb_bank[p][BANK] && valid_q[wb_addr[p]]) begin
          done_q[wb_addr[p]] <= 1'b1;
        end
      end
      if (clr_en) begin
        valid_q[rd_addr] <= 1'b0;
        done_q[rd_addr]  <= 1'b0;
      end
      if (wr_en) begin
        valid_q[wr_addr] <= wr_valid;
        done_q[wr_addr]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      phys_q[wr_addr] <= wr_phys_rd;
      arch_q[wr_addr] <= wr_arch_rd;
    end
  end

  assign rd_entry.valid   = valid_q[rd_addr];
  assign rd_entry.done    = done_q[rd_addr];
  assign rd_entry.phys_rd = phys_q[rd_addr];
  assign rd_entry.arch_rd = arch_q[rd_addr];
endmodule

// File: rtl/reorder_buffer.sv
// In-order banked reorder buffer: row allocation, writeback tracking, head-row retire.
// Define ROB_WB_BYPASS_EN to let same-cycle writebacks make the head row eligible.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dispatch_en        [0:DISPATCH_WIDTH-1],
  input  logic [PHYS_REGS_ADDR_WIDTH-1:0] dispatch_phys_rd   [0:DISPATCH_WIDTH-1],
  input  logic [4:0]                      dispatch_arch_rd   [0:DISPATCH_WIDTH-1],
  output logic [ROB_ADDR_WIDTH-1:0]       dispatch_rob_addr  [0:DISPATCH_WIDTH-1],
  output logic [DISPATCH_WIDTH-1:0]       dispatch_bank_addr [0:DISPATCH_WIDTH-1],
  output logic                            full,
  output logic                            empty,
  input  logic                            writeback_en        [0:DISPATCH_WIDTH-1],
  input  logic [ROB_ADDR_WIDTH-1:0]       writeback_rob_addr  [0:DISPATCH_WIDTH-1],
  input  logic [DISPATCH_WIDTH-1:0]       writeback_bank_addr [0:DISPATCH_WIDTH-1],
  output logic                            commit_en      [0:DISPATCH_WIDTH-1],
  output logic [PHYS_REGS_ADDR_WIDTH-1:0] commit_phys_rd [0:DISPATCH_WIDTH-1],
  output logic [4:0]                      commit_arch_rd [0:DISPATCH_WIDTH-1]
);
  localparam int AW = ROB_ADDR_WIDTH;

  logic [AW:0]               head_q, head_d, tail_q, tail_d;
  logic [AW-1:0]             head_idx, tail_idx;
  logic                      dispatch_any, do_dispatch, row_ready, do_commit;
  logic [DISPATCH_WIDTH-1:0] wb_hit;
  rob_entry_t                head_entry [0:DISPATCH_WIDTH-1];

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
  assign empty    = (head_q == tail_q);

  always_comb begin
    dispatch_any = 1'b0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) dispatch_any = dispatch_any | dispatch_en[i];
  end
  assign do_dispatch = dispatch_any && !full;

`ifdef ROB_WB_BYPASS_EN
  always_comb begin
    wb_hit = '0;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      for (int p = 0; p < DISPATCH_WIDTH; p++) begin
        if (writeback_en[p] && (writeback_rob_addr[p] == head_idx) && writeback_bank_addr[p][b]) begin
          wb_hit[b] = 1'b1;
        end
      end
    end
  end
`else
  assign wb_hit = '0;
`endif

  always_comb begin
    row_ready = 1'b1;
    for (int b = 0; b < DISPATCH_WIDTH; b++) begin
      if (head_entry[b].valid && !(head_entry[b].done || wb_hit[b])) row_ready = 1'b0;
    end
  end
  assign do_commit = !empty && row_ready;

  assign head_d = head_q + (AW+1)'(do_commit);
  assign tail_d = tail_q + (AW+1)'(do_dispatch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  for (genvar b = 0; b < DISPATCH_WIDTH; b++) begin : g_bank
    rob_bank #(.BANK(b)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (do_dispatch),
      .wr_addr    (tail_idx),
      .wr_valid   (dispatch_en[b]),
      .wr_phys_rd (dispatch_phys_rd[b]),
      .wr_arch_rd (dispatch_arch_rd[b]),
      .wb_en      (writeback_en),
      .wb_addr    (writeback_rob_addr),
      .wb_bank    (writeback_bank_addr),
      .clr_en     (do_commit),
      .rd_addr    (head_idx),
      .rd_entry   (head_entry[b])
    );

    assign dispatch_rob_addr[b]  = tail_idx;
    assign dispatch_bank_addr[b] = DISPATCH_WIDTH'(1) << b;
    assign commit_en[b]          = do_commit && head_entry[b].valid;
    assign commit_phys_rd[b]     = head_entry[b].phys_rd;
    assign commit_arch_rd[b]     = head_entry[b].arch_rd;
  end
endmodule
